// File: rtl/mem_lsu_pkg.sv
// Shared encodings and byte-lane helpers for the load/store port.
// Lane functions assume a 32-bit little-endian word.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            SZ_WORD: r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Overlay the right-aligned store data onto the old word at the addressed lanes.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = old_word;
        case (size)
            SZ_BYTE: r[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: r[{off[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_WORD: r = wdata;
            default: r = old_word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lsu_port_lane_align.sv
// Combinational byte-lane steering: load extract/extend and sub-word store merge.
module mem_lane_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    assign load_data_o  = lane_extract(rd_word_i, off_i, size_i, signed_i);
    assign merge_data_o = lane_merge(rd_word_i, wdata_i, off_i, size_i);

endmodule

// File: rtl/mem_lsu_port.sv
// Single-outstanding load/store initiator for a 2**ADDR_W x 32 dual-port memory.
// Handshake: a request transfers on a rising edge with req_valid & req_ready; rsp_valid is a one-cycle pulse with no backpressure.
module mem_lsu_port
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_dpra,
    input  logic [DATA_W-1:0] mem_dpo,
    output lsu_state_e        dbg_state_o
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, a_q, dpra_q;
    logic [1:0]        off_q, size_q;
    logic              signed_q, we_q, err_q;
    logic [31:0]       wdata_q, merge_q, rdata_q;

    logic              accept;
    logic              acc_err;
    logic [ADDR_W-1:0] req_idx;
    logic [31:0]       load_data, merge_data;

    assign req_idx = req_addr[ADDR_W+1:2];
    assign accept  = req_valid & req_ready;

    assign acc_err = (req_size == 2'b11)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                   | (|req_addr[31:ADDR_W+2]);

    mem_lane_align u_align (
        .rd_word_i    (mem_dpo),
        .wdata_i      (wdata_q),
        .off_i        (off_q),
        .size_i       (size_q),
        .signed_i     (signed_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_err)
                        state_d = ST_RESP;
                    else if (!req_we || (req_size != SZ_WORD))
                        state_d = ST_RD;
                    else
                        state_d = ST_WR;
                end
            end
            ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            dpra_q   <= '0;
            off_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q    <= req_idx;
                off_q    <= req_addr[1:0];
                size_q   <= req_size;
                signed_q <= req_signed;
                we_q     <= req_we;
                wdata_q  <= req_wdata;
                err_q    <= acc_err;
                rdata_q  <= '0;
            end
            if ((state_q == ST_IDLE) && (state_d == ST_RD))
                dpra_q <= req_idx;
            if ((state_q == ST_RD) && !we_q)
                rdata_q <= load_data;
            if (state_q == ST_RD)
                merge_q <= merge_data;
            // Word stores enter WR straight from IDLE, before idx_q is valid.
            if (state_d == ST_WR)
                a_q <= (state_q == ST_IDLE) ? req_idx : idx_q;
        end
    end

    assign req_ready   = (state_q == ST_IDLE) & rst_n;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_err     = err_q;
    assign rsp_rdata   = rdata_q;
    assign mem_we      = (state_q == ST_WR) & rst_n;
    assign mem_a       = a_q;
    assign mem_dpra    = dpra_q;
    assign mem_d       = (state_q == ST_WR) ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_lsu_port.sv
// Directed bench for mem_lsu_port: scoreboard queues for responses and memory writes.
module tb_mem_lsu_port;
    import mem_lsu_pkg::*;

    localparam int RW = 69;  // {accept_cycle[31:0], latency[3:0], err, rdata[31:0]}
    localparam int WW = 41;  // {addr[8:0], data[31:0]}
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, RSV = 2'b11;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [8:0]  mem_a, mem_dpra;
    logic [31:0] mem_d, mem_dpo;
    logic        mem_we;
    lsu_state_e  dbg_state;

    logic [31:0]   mem [0:511];
    logic [31:0]   cyc;
    logic [RW-1:0] exp_q[$];
    logic [WW-1:0] wr_q[$];
    int            checks, failures;

    mem_lsu_port #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
        .mem_dpra(mem_dpra), .mem_dpo(mem_dpo), .dbg_state_o(dbg_state)
    );

    // Clock, cycle counter and memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    assign mem_dpo = mem[mem_dpra];
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever the DUT produces a response or a memory write
    always @(negedge clk) begin
        logic [RW-1:0] e;
        logic [WW-1:0] w;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(e[32]));
                chk("rsp_rdata", rsp_rdata, e[31:0]);
                chk("rsp_latency", cyc - e[68:37], 32'(e[36:33]));
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_mem_we", 32'(mem_we), 32'd0);
            end else begin
                w = wr_q.pop_front();
                chk("mem_a", 32'(mem_a), 32'(w[40:32]));
                chk("mem_d", mem_d, w[31:0]);
            end
        end
    end

    // Driver: present a request, wait for acceptance, return the pre-edge cycle number
    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output logic [31:0] acc);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_signed = sgn; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            $display("FAIL req_ready_timeout actual=0 expected=1");
            $fatal(1, "request never accepted");
        end
        acc = cyc;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] lat, input logic err, input logic [31:0] rdata);
        logic [31:0] acc;
        send(we, size, sgn, addr, wdata, 1'b0, acc);
        exp_q.push_back({acc, lat, err, rdata});
    endtask

    task automatic exp_wr(input logic [8:0] a, input logic [31:0] d);
        wr_q.push_back({a, d});
    endtask

    initial begin
        logic [31:0] acc;
        int n;
        checks = 0; failures = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);

        // Word store/load, then sub-word stores by read-modify-write
        exp_wr(9'd1, 32'hDEADBEEF);
        txn(1, W, 0, 32'h004, 32'hDEADBEEF, 4'd2, 0, 32'h0);
        txn(0, W, 0, 32'h004, 32'h0,        4'd2, 0, 32'hDEADBEEF);
        exp_wr(9'd1, 32'hDEADAAEF);
        txn(1, B, 0, 32'h005, 32'h000000AA, 4'd3, 0, 32'h0);
        txn(0, B, 1, 32'h005, 32'h0,        4'd2, 0, 32'hFFFFFFAA);
        txn(0, B, 0, 32'h005, 32'h0,        4'd2, 0, 32'h000000AA);
        exp_wr(9'd1, 32'h1234AAEF);
        txn(1, H, 0, 32'h006, 32'h00001234, 4'd3, 0, 32'h0);
        txn(0, H, 1, 32'h006, 32'h0,        4'd2, 0, 32'h00001234);
        txn(0, W, 0, 32'h004, 32'h0,        4'd2, 0, 32'h1234AAEF);
        txn(0, H, 1, 32'h004, 32'h0,        4'd2, 0, 32'hFFFFAAEF);
        txn(0, B, 1, 32'h004, 32'h0,        4'd2, 0, 32'hFFFFFFEF);
        txn(0, B, 0, 32'h007, 32'h0,        4'd2, 0, 32'h00000012);

        // Error cases: no memory write, 1-cycle response, zero data
        txn(0, W,   0, 32'h006, 32'h0,        4'd1, 1, 32'h0);
        txn(1, H,   0, 32'h003, 32'h00005555, 4'd1, 1, 32'h0);
        txn(0, W,   0, 32'h800, 32'h0,        4'd1, 1, 32'h0);
        txn(0, RSV, 0, 32'h000, 32'h0,        4'd1, 1, 32'h0);

        // Highest in-range word
        exp_wr(9'd511, 32'hCAFEF00D);
        txn(1, W, 0, 32'h7FC, 32'hCAFEF00D, 4'd2, 0, 32'h0);
        txn(0, W, 0, 32'h7FC, 32'h0,        4'd2, 0, 32'hCAFEF00D);

        // Reset during WR of a sub-word store drops it entirely
        exp_wr(9'd2, 32'h11223344);
        txn(1, W, 0, 32'h008, 32'h11223344, 4'd2, 0, 32'h0);
        send(1, B, 0, 32'h008, 32'h00000055, 1'b0, acc);
        @(posedge clk);
        #1;
        chk("state_before_reset", 32'(dbg_state), 32'(ST_WR));
        rst_n = 1'b0;
        #1;
        chk("mem_we_in_reset", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        txn(0, W, 0, 32'h008, 32'h0, 4'd2, 0, 32'h11223344);

        // Back-to-back with req_valid held: second request waits for IDLE
        exp_wr(9'd3, 32'h0BADF00D);
        send(1, W, 0, 32'h00C, 32'h0BADF00D, 1'b1, acc);
        exp_q.push_back({acc, 4'd2, 1'b0, 32'h0});
        req_we = 1'b0; req_wdata = '0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 32'(n), 32'd2);
        acc = cyc;
        exp_q.push_back({acc, 4'd2, 1'b0, 32'h0BADF00D});
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
